// File: rtl/st_ram_writer.sv
// Avalon-ST to single-port RAM writer: stores one packet starting at BASE, up to LIMIT words,
// with a 4-register CSR slave, DONE status and level IRQ.
`timescale 1ns/1ps
module st_ram_writer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 10000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_empty,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  output logic              irq
);

  typedef enum logic [2:0] {IDLE, WAIT_SOP, RUN, DRAIN, DONE_S} state_t;
  state_t state;

  logic              irq_en, done, overrun, sop_err;
  logic [ADDR_W-1:0] base, ptr, ptr_next;
  logic [CNT_W-1:0]  limit, lim_q, count, count_inc;
  logic              csr_wr, go, abort, busy, accept, wr_beat;
  logic [3:0]        eop_be;
  logic              unused;

  assign csr_wr    = csr_chipselect & csr_write;
  assign abort     = csr_wr && (csr_address == 2'd0) && csr_writedata[1];
  assign go        = csr_wr && (csr_address == 2'd0) && csr_writedata[0] && !csr_writedata[1];
  assign busy      = (state != IDLE);
  assign in_ready  = (state inside {WAIT_SOP, RUN, DRAIN});
  assign accept    = in_valid & in_ready;
  // A beat accepted in the same cycle as ABORT is dropped.
  assign wr_beat   = accept && !abort && (((state == WAIT_SOP) && in_sop) || (state == RUN));
  assign eop_be    = 4'b1111 >> in_empty;
  assign ptr_next  = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign count_inc = count + 1'b1;
  assign irq       = done & irq_en;
  assign ram_clken = 1'b1;
  assign unused    = ^csr_writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
      ptr            <= '0;
      base           <= '0;
      limit          <= '0;
      lim_q          <= '0;
      count          <= '0;
      irq_en         <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      sop_err        <= 1'b0;
    end else begin
      ram_chipselect <= wr_beat;
      ram_write      <= wr_beat;
      if (wr_beat) begin
        ram_address    <= ptr;
        ram_writedata  <= in_data;
        ram_byteenable <= in_eop ? eop_be : 4'b1111;
        ptr            <= ptr_next;
      end

      if (csr_wr) begin
        case (csr_address)
          2'd0: irq_en <= csr_writedata[2];
          2'd1: base   <= csr_writedata[ADDR_W-1:0];
          2'd2: limit  <= csr_writedata[CNT_W-1:0];
          default: begin
            if (csr_writedata[1]) done    <= 1'b0;
            if (csr_writedata[2]) overrun <= 1'b0;
            if (csr_writedata[3]) sop_err <= 1'b0;
          end
        endcase
      end

      // Hardware updates follow the CSR writes so a DONE set beats a same-cycle W1C.
      if (abort && busy) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (go) begin
            ptr     <= (32'(base) >= DEPTH) ? '0 : base;
            lim_q   <= limit;
            count   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            sop_err <= 1'b0;
            state   <= (limit == '0) ? DONE_S : WAIT_SOP;
          end
          WAIT_SOP: if (accept && in_sop) begin
            count <= CNT_W'(1);
            if (in_eop) begin
              state <= DONE_S;
            end else if (lim_q == CNT_W'(1)) begin
              state   <= DRAIN;
              overrun <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
          RUN: if (accept) begin
            count <= count_inc;
            if (in_sop) sop_err <= 1'b1;
            if (in_eop) begin
              state <= DONE_S;
            end else if (count_inc == lim_q) begin
              state   <= DRAIN;
              overrun <= 1'b1;
            end
          end
          DRAIN: if (accept && in_eop) state <= DONE_S;
          DONE_S: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    csr_readdata = '0;
    if (csr_chipselect && csr_read) begin
      case (csr_address)
        2'd0: csr_readdata[2] = irq_en;
        2'd1: csr_readdata[ADDR_W-1:0] = base;
        2'd2: csr_readdata[CNT_W-1:0] = limit;
        default: begin
          csr_readdata[0]           = busy;
          csr_readdata[1]           = done;
          csr_readdata[2]           = overrun;
          csr_readdata[3]           = sop_err;
          csr_readdata[16 +: CNT_W] = count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_ram_writer.sv
// Self-checking bench for st_ram_writer: directed packet table, hand-written abort/reset
// sequences, and randomized packets checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_st_ram_writer;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 10000;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        csr_address = '0;
  logic              csr_chipselect = 1'b0, csr_write = 1'b0, csr_read = 1'b0;
  logic [31:0]       csr_writedata = '0, csr_readdata;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]        in_empty = '0;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write, ram_clken, irq;
  logic [31:0]       ram_writedata;
  logic [3:0]        ram_byteenable;

  always #5 clk = ~clk;

  st_ram_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_chipselect(csr_chipselect), .csr_write(csr_write),
    .csr_read(csr_read), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .irq(irq)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
    int unsigned       cyc;
  } wr_t;
  typedef struct {
    logic [31:0] data;
    bit          sop, eop;
    logic [1:0]  empty;
  } beat_t;

  int checks = 0, failures = 0, cs_bad = 0;
  int unsigned cyc = 0;
  wr_t   wr_q[$];
  wr_t   exp_q[$];
  int unsigned acc_q[$];
  beat_t pkt[$];

  always @(negedge clk) begin
    if (ram_write) wr_q.push_back('{ram_address, ram_writedata, ram_byteenable, cyc});
    if (ram_chipselect !== ram_write || ram_clken !== 1'b1) cs_bad++;
    if (in_valid && in_ready) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
    #1 d = csr_readdata;
    csr_chipselect = 1'b0; csr_read = 1'b0;
  endtask

  task automatic send_beat(input beat_t b, input int unsigned gap);
    logic acc;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = b.data; in_sop = b.sop; in_eop = b.eop; in_empty = b.empty; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
    chk("beat_accept_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    for (int i = 0; i < 200; i++) begin
      csr_rd(2'd3, s);
      if (!s[0]) begin repeat (2) @(negedge clk); return; end
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic start(input int unsigned base, input int unsigned limit, input bit ien);
    csr_wr(2'd2, limit);
    csr_wr(2'd1, base);
    wr_q.delete(); acc_q.delete();
    csr_wr(2'd0, ien ? 32'h5 : 32'h1);
  endtask

  // Packet-level reference: which beats become writes, where, and with which lanes.
  function automatic void model(input int unsigned base, input int unsigned limit,
                                output int unsigned cnt, output bit ov, output bit se,
                                output int unsigned used);
    int unsigned addr = (base >= DEPTH) ? 0 : base;
    bit started = 0, dropping = 0;
    wr_t w;
    exp_q.delete(); cnt = 0; ov = 0; se = 0; used = 0;
    if (limit == 0) return;
    foreach (pkt[i]) begin
      used = i + 1;
      if (!started && !pkt[i].sop) continue;
      if (dropping) begin
        if (pkt[i].eop) return;
        continue;
      end
      if (started && pkt[i].sop) se = 1;
      started = 1;
      w.addr = addr[ADDR_W-1:0];
      w.data = pkt[i].data;
      w.be   = pkt[i].eop ? 4'((1 << (4 - pkt[i].empty)) - 1) : 4'hF;
      w.cyc  = 0;
      exp_q.push_back(w);
      addr = (addr + 1) % DEPTH;
      cnt++;
      if (pkt[i].eop) return;
      if (cnt == limit) begin ov = 1; dropping = 1; end
    end
  endfunction

  typedef struct {
    int unsigned base, limit, nbeats, nstray, midsop;
    logic [1:0]  empty;
    int unsigned e_nwr, e_first, e_last;
    logic [3:0]  e_lastbe;
    int unsigned e_count;
    bit          e_ov, e_se;
  } vec_t;

  initial begin
    vec_t        vt[9];
    logic [31:0] s;
    beat_t       b;
    bit          ok, ov, se, ien;
    int unsigned cnt, used, errs, lim, bs;

    // base, limit, nbeats, nstray, midsop, empty | nwr, first, last, lastbe, count, ov, se
    vt[0] = '{32'h10, 8, 4, 0, 0, 2'd0, 4, 32'h10, 32'h13, 4'hF, 4, 1'b0, 1'b0};
    vt[1] = '{0,      8, 3, 0, 0, 2'd2, 3, 0,      2,      4'h3, 3, 1'b0, 1'b0};
    vt[2] = '{32'h20, 2, 5, 0, 0, 2'd0, 2, 32'h20, 32'h21, 4'hF, 2, 1'b1, 1'b0};
    vt[3] = '{9998,   8, 4, 0, 0, 2'd0, 4, 9998,   1,      4'hF, 4, 1'b0, 1'b0};
    vt[4] = '{5,      8, 3, 2, 0, 2'd1, 3, 5,      7,      4'h7, 3, 1'b0, 1'b0};
    vt[5] = '{0,      8, 4, 0, 2, 2'd0, 4, 0,      3,      4'hF, 4, 1'b0, 1'b1};
    vt[6] = '{32'h100,0, 3, 0, 0, 2'd0, 0, 0,      0,      4'hF, 0, 1'b0, 1'b0};
    vt[7] = '{12000,  4, 2, 0, 0, 2'd3, 2, 0,      1,      4'h1, 2, 1'b0, 1'b0};
    vt[8] = '{32'h40, 1, 3, 0, 0, 2'd0, 1, 32'h40, 32'h40, 4'hF, 1, 1'b1, 1'b0};

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_write", {ram_chipselect, ram_write}, 0);
    chk("rst_ram_addr", ram_address, 0);
    chk("rst_ram_be", ram_byteenable, 0);
    chk("rst_irq", irq, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), s);
      chk($sformatf("rst_csr%0d", a), s, 0);
    end

    for (int v = 0; v < 9; v++) begin
      start(vt[v].base, vt[v].limit, 1'b1);
      if (vt[v].limit != 0) begin
        for (int j = 0; j < int'(vt[v].nstray); j++)
          send_beat('{32'h5000 + j, 1'b0, 1'b0, 2'd0}, 0);
        for (int j = 0; j < int'(vt[v].nbeats); j++) begin
          b.data  = 32'hA0 + j;
          b.sop   = (j == 0) || (vt[v].midsop != 0 && j == int'(vt[v].midsop));
          b.eop   = (j == int'(vt[v].nbeats) - 1);
          b.empty = b.eop ? vt[v].empty : 2'd0;
          send_beat(b, 0);
        end
      end
      wait_idle();
      chk($sformatf("v%0d_nwr", v), wr_q.size(), vt[v].e_nwr);
      if (vt[v].limit != 0)
        chk($sformatf("v%0d_naccepted", v), acc_q.size(), vt[v].nstray + vt[v].nbeats);
      if (vt[v].e_nwr > 0 && wr_q.size() == vt[v].e_nwr) begin
        chk($sformatf("v%0d_first_addr", v), wr_q[0].addr, vt[v].e_first);
        chk($sformatf("v%0d_last_addr", v), wr_q[$].addr, vt[v].e_last);
        chk($sformatf("v%0d_first_data", v), wr_q[0].data, 32'hA0);
        chk($sformatf("v%0d_last_be", v), wr_q[$].be, vt[v].e_lastbe);
        chk($sformatf("v%0d_latency", v), wr_q[0].cyc, acc_q[vt[v].nstray] + 1);
        ok = 1;
        for (int i = 0; i < int'(vt[v].e_nwr); i++) begin
          if (wr_q[i].addr != ADDR_W'((vt[v].e_first + i) % DEPTH)) ok = 0;
          if (wr_q[i].cyc != wr_q[0].cyc + i) ok = 0;
          if (i < int'(vt[v].e_nwr) - 1 && wr_q[i].be != 4'hF) ok = 0;
        end
        chk($sformatf("v%0d_seq_addr_cyc_be", v), ok, 1);
      end
      csr_rd(2'd3, s);
      chk($sformatf("v%0d_busy_done", v), s[1:0], 2'b10);
      chk($sformatf("v%0d_overrun", v), s[2], vt[v].e_ov);
      chk($sformatf("v%0d_soperr", v), s[3], vt[v].e_se);
      chk($sformatf("v%0d_count", v), s[31:16], vt[v].e_count);
      chk($sformatf("v%0d_irq", v), irq, 1);
    end

    csr_wr(2'd3, 32'h2);
    csr_rd(2'd3, s);
    chk("w1c_done", s[1], 0);
    chk("w1c_irq", irq, 0);
    chk("w1c_keeps_overrun", s[2], 1);

    // Abort after two accepted beats, then ABORT+GO from IDLE.
    start(32'h30, 8, 1'b1);
    send_beat('{32'hB0, 1'b1, 1'b0, 2'd0}, 0);
    send_beat('{32'hB1, 1'b0, 1'b0, 2'd0}, 0);
    csr_wr(2'd0, 32'h6);
    repeat (3) @(negedge clk);
    chk("abort_nwr", wr_q.size(), 2);
    chk("abort_in_ready", in_ready, 0);
    csr_rd(2'd3, s);
    chk("abort_busy_done", s[1:0], 2'b00);
    chk("abort_count", s[31:16], 2);
    chk("abort_irq", irq, 0);
    csr_wr(2'd0, 32'h7);
    repeat (2) @(negedge clk);
    csr_rd(2'd3, s);
    chk("abort_go_idle", s[0], 0);
    chk("abort_go_count_kept", s[31:16], 2);
    csr_rd(2'd0, s);
    chk("ctrl_readback", s, 32'h4);

    for (int t = 0; t < 30; t++) begin
      bs  = ($urandom_range(0, 3) == 0) ? DEPTH - 3 + $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1);
      lim = $urandom_range(0, 6);
      ien = 1'($urandom_range(0, 1));
      pkt.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        pkt.push_back('{$urandom, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom)});
      cnt = $urandom_range(1, 8);
      for (int j = 0; j < int'(cnt); j++) begin
        b.data  = $urandom;
        b.sop   = (j == 0) || ($urandom_range(0, 5) == 0);
        b.eop   = (j == int'(cnt) - 1);
        b.empty = 2'($urandom);
        pkt.push_back(b);
      end
      model(bs, lim, cnt, ov, se, used);
      start(bs, lim, ien);
      for (int j = 0; j < int'(used); j++) send_beat(pkt[j], $urandom_range(0, 2));
      wait_idle();
      chk($sformatf("r%0d_nwr", t), wr_q.size(), exp_q.size());
      errs = 0;
      if (wr_q.size() == exp_q.size())
        foreach (exp_q[i])
          if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data ||
              wr_q[i].be !== exp_q[i].be) errs++;
      chk($sformatf("r%0d_writes", t), errs, 0);
      csr_rd(2'd3, s);
      chk($sformatf("r%0d_status", t), {s[31:16], s[3:0]}, {16'(cnt), se, ov, 2'b10});
      chk($sformatf("r%0d_irq", t), irq, ien);
    end

    // Asynchronous reset while a write strobe is high.
    start(32'h55, 8, 1'b1);
    send_beat('{32'hDEAD, 1'b1, 1'b0, 2'd0}, 0);
    chk("pre_reset_write", ram_write, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_write", {ram_chipselect, ram_write}, 0);
    chk("async_rst_addr", ram_address, 0);
    chk("async_rst_data", ram_writedata, 0);
    chk("async_rst_be", ram_byteenable, 0);
    chk("async_rst_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    csr_rd(2'd3, s);
    chk("post_reset_status", s, 0);

    chk("cs_equals_write_clken", cs_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
